// File: rtl/mux16_sched.sv
// Round-robin scheduler for a shared 16:1 select mux: one owner at a time,
// held until release or until MAX_HOLD cycles elapse, then priority rotates.
module mux16_sched #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        valid,
  output logic        timeout,
  output logic        state_dbg,
  output logic [3:0]  ptr_dbg
);

  // Handshake: a grant is offered by raising valid with grant == 1<<sel; the
  // owner ends it by pulsing done (or dropping req[sel]) while valid is high.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [15:0] grant_n;
  logic [3:0]  sel_n;
  logic        valid_n, timeout_n;
  logic [3:0]  win, idx;
  logic        found;

  // Rotating scan: first set request at or above ptr, wrapping past 15.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    grant_n   = grant;
    sel_n     = sel;
    valid_n   = valid;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_n   = win;
          grant_n = 16'd1 << win;
          valid_n = 1'b1;
          hold_n  = 8'd0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // Owner release outranks the hold limit, so a coincident done never times out.
        if (done || !req[sel] || hold_cnt == HOLD_LAST) begin
          timeout_n = !(done || !req[sel]);
          valid_n   = 1'b0;
          grant_n   = 16'd0;
          ptr_n     = sel + 4'd1;
          state_n   = IDLE;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      hold_cnt <= 8'd0;
      grant    <= 16'd0;
      sel      <= 4'd0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      sel      <= sel_n;
      valid    <= valid_n;
      timeout  <= timeout_n;
    end
  end

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_mux16_sched.sv
// Bench for mux16_sched: directed grants, each expected grant record
// {sel, length, timeout} queued by the driver and checked by a monitor.
module tb_mux16_sched;

  localparam int W = 13;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        valid;
  logic        timeout;
  logic        state_dbg;
  logic [3:0]  ptr_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  mux16_sched #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .sel(sel), .valid(valid), .timeout(timeout),
    .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [3:0] s, input int len, input logic to);
    exp_q.push_back({s, 8'(len), to});
  endtask

  // Holds req, lets the grant run n cycles, then pulses done in cycle n.
  task automatic grant_with_done(input logic [15:0] r, input int n);
    req = r;
    repeat (n) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic       active;
    logic [3:0] cur_sel;
    int         len;
    logic [W-1:0] got, want;
    active = 1'b0;
    cur_sel = 4'd0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (valid) begin
        chk("grant_onehot", grant, 32'(16'd1 << sel));
        chk("timeout_in_grant", timeout, 0);
        if (!active) begin
          active  = 1'b1;
          cur_sel = sel;
          len     = 1;
        end else begin
          len++;
          chk("sel_stable", sel, cur_sel);
        end
      end else begin
        chk("grant_idle", grant, 0);
        if (active) begin
          active = 1'b0;
          got = {cur_sel, 8'(len), timeout};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: got sel=%0d len=%0d to=%0b, none expected",
                     cur_sel, len, timeout);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL grant_record: got sel=%0d len=%0d to=%0b expected sel=%0d len=%0d to=%0b",
                       got[12:9], got[8:1], got[0], want[12:9], want[8:1], want[0]);
            end
          end
        end else begin
          chk("timeout_spurious", timeout, 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;

    // reset with all requests asserted
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_sel", sel, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_ptr", ptr_dbg, 0);
      chk("rst_state", state_dbg, 0);
    end
    tick();
    rst = 1'b0;
    req = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", valid, 0);
      chk("idle_sel", sel, 0);
    end

    // single requester, done in 3rd grant cycle
    expect_grant(4'd5, 3, 1'b0);
    grant_with_done(16'h0020, 3);
    req = 16'h0000;
    @(negedge clk);
    chk("ptr_after_5", ptr_dbg, 6);
    chk("sel_held_after_release", sel, 5);

    // round robin from ptr=6: 15, 0, 15, 0
    expect_grant(4'd15, 1, 1'b0);
    expect_grant(4'd0, 1, 1'b0);
    expect_grant(4'd15, 1, 1'b0);
    expect_grant(4'd0, 1, 1'b0);
    grant_with_done(16'h8001, 1);
    @(negedge clk);
    chk("ptr_wrap", ptr_dbg, 0);
    grant_with_done(16'h8001, 1);
    grant_with_done(16'h8001, 1);
    grant_with_done(16'h8001, 1);
    req = 16'h0000;
    @(negedge clk);
    chk("ptr_after_rr", ptr_dbg, 1);

    // hold limit, then done coinciding with expiry on the re-grant
    expect_grant(4'd8, 8, 1'b1);
    expect_grant(4'd8, 8, 1'b0);
    req = 16'h0100;
    repeat (9) tick();
    grant_with_done(16'h0100, 8);
    req = 16'h0000;
    @(negedge clk);
    chk("ptr_after_8", ptr_dbg, 9);
    chk("no_timeout_on_done", timeout, 0);

    // requester drops its request in the 3rd grant cycle
    expect_grant(4'd9, 3, 1'b0);
    req = 16'h0600;
    repeat (3) tick();
    req = 16'h0400;
    tick();
    @(negedge clk);
    chk("drop_valid", valid, 0);
    chk("drop_ptr", ptr_dbg, 10);

    // async reset in the middle of grant to input 10
    tick();
    tick();
    chk("pre_rst_valid", valid, 1);
    chk("pre_rst_sel", sel, 10);
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_grant", grant, 0);
    chk("async_ptr", ptr_dbg, 0);
    chk("async_timeout", timeout, 0);
    chk("async_state", state_dbg, 0);
    tick();
    rst = 1'b0;
    req = 16'h0000;
    @(negedge clk);
    chk("post_rst_timeout", timeout, 0);

    // arbitration restarts from ptr=0
    expect_grant(4'd2, 2, 1'b0);
    grant_with_done(16'h8004, 2);
    req = 16'h0000;

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("queue_drained", exp_q.size(), 0);
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
